// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one synchronous instruction-memory read per cycle
// and hands fetched words to decode through a 2-entry valid/ready queue.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned NUM_INSTR = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  localparam logic [32:0] PC_LIMIT = 33'(NUM_INSTR) * 33'd4;

  typedef enum logic [1:0] {RUN, STALL, FAULT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pending_q, pending_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] instr_q [2];
  logic [31:0] instr_d [2];
  logic [31:0] qpc_q [2];
  logic [31:0] qpc_d [2];
  logic [1:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  logic        pop;
  logic [1:0]  cnt_pop;
  logic        credit_ok;
  logic        pc_bad;
  logic        redir_bad;

  always_comb begin
    pop       = (cnt_q != 2'd0) && out_ready;
    cnt_pop   = cnt_q - {1'b0, pop};
    credit_ok = ({1'b0, cnt_pop} + {2'b00, pending_q}) <= 3'd1;
    pc_bad    = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} >= PC_LIMIT);
    redir_bad = (redirect_pc[1:0] != 2'b00) || ({1'b0, redirect_pc} >= PC_LIMIT);

    state_d    = state_q;
    pc_d       = pc_q;
    pending_d  = pending_q;
    req_pc_d   = req_pc_q;
    instr_d    = instr_q;
    qpc_d      = qpc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;

    // Pop shifts the tail into the head; the returning word lands in the first free slot.
    if (pop) begin
      instr_d[0] = instr_q[1];
      qpc_d[0]   = qpc_q[1];
    end
    if (pending_q) begin
      instr_d[cnt_pop[0]] = imem_instr;
      qpc_d[cnt_pop[0]]   = req_pc_q;
    end
    cnt_d = cnt_pop + {1'b0, pending_q};

    if (redirect_valid) begin
      cnt_d     = 2'd0;
      pending_d = 1'b0;
      pc_d      = redirect_pc;
      if (redir_bad) begin
        state_d    = FAULT;
        fault_d    = 1'b1;
        fault_pc_d = redirect_pc;
      end else begin
        state_d = RUN;
        fault_d = 1'b0;
      end
    end else if (state_q == FAULT) begin
      pending_d = 1'b0;
    end else if (pc_bad) begin
      // Walking off the end still lets the last legal word drain out of the queue.
      state_d    = FAULT;
      pending_d  = 1'b0;
      fault_d    = 1'b1;
      fault_pc_d = pc_q;
    end else if (credit_ok) begin
      state_d   = RUN;
      pending_d = 1'b1;
      req_pc_d  = pc_q;
      pc_d      = pc_q + 32'd4;
    end else begin
      state_d   = STALL;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      pending_q  <= 1'b0;
      req_pc_q   <= 32'd0;
      instr_q[0] <= 32'd0;
      instr_q[1] <= 32'd0;
      qpc_q[0]   <= 32'd0;
      qpc_q[1]   <= 32'd0;
      cnt_q      <= 2'd0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pending_q  <= pending_d;
      req_pc_q   <= req_pc_d;
      instr_q[0] <= instr_d[0];
      instr_q[1] <= instr_d[1];
      qpc_q[0]   <= qpc_d[0];
      qpc_q[1]   <= qpc_d[1];
      cnt_q      <= cnt_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign imem_addr   = pc_q;
  assign out_valid   = (cnt_q != 2'd0);
  assign out_instr   = instr_q[0];
  assign out_pc      = qpc_q[0];
  assign fetch_fault = fault_q;
  assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a scoreboard of expected fetch PCs is refilled on every
// reset/redirect and drained by the decode-side monitor; a second small instance checks overflow.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, redirectValid, outReady;
  logic [31:0] redirectPc, imemAddr, imemInstr, outInstr, outPc, faultPc;
  logic        outValid, fetchFault;

  logic        rst4;
  logic [31:0] imemAddr4, imemInstr4, outInstr4, outPc4, faultPc4;
  logic        outValid4, fetchFault4;

  int vectors = 0;
  int miscompares = 0;
  int xferCount = 0;
  logic [31:0] expQ[$];

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0), .NUM_INSTR(1024)) dut (
    .clk(clk), .rst(rst), .imem_addr(imemAddr), .imem_instr(imemInstr),
    .redirect_valid(redirectValid), .redirect_pc(redirectPc),
    .out_valid(outValid), .out_ready(outReady), .out_instr(outInstr), .out_pc(outPc),
    .fetch_fault(fetchFault), .fault_pc(faultPc)
  );

  fetch_ctrl #(.RESET_PC(32'h0), .NUM_INSTR(4)) dut4 (
    .clk(clk), .rst(rst4), .imem_addr(imemAddr4), .imem_instr(imemInstr4),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(outValid4), .out_ready(1'b1), .out_instr(outInstr4), .out_pc(outPc4),
    .fetch_fault(fetchFault4), .fault_pc(faultPc4)
  );

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr >> 2) + 32'h100;
  endfunction

  // Synchronous memories: the word for this cycle's address appears next cycle.
  always @(posedge clk) begin
    imemInstr  <= memWord(imemAddr);
    imemInstr4 <= memWord(imemAddr4);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Every accepted instruction must be the next one the scoreboard predicts.
  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      xferCount++;
      if (expQ.size() == 0) begin
        checkOutput("sbUnexpected", outPc, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = expQ.pop_front();
        checkOutput("sbPc", outPc, e);
        checkOutput("sbInstr", outInstr, memWord(e));
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pushStream(input logic [31:0] startPc);
    expQ.delete();
    for (int i = 0; i < 64; i++) expQ.push_back(startPc + 32'(i) * 32'd4);
  endtask

  task automatic applyStimulus(input logic [31:0] pc);
    redirectValid = 1'b1;
    redirectPc    = pc;
    stepCycle();
    redirectValid = 1'b0;
  endtask

  task automatic resetAndCheck(input string tag);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    redirectValid = 1'b0;
    outReady = 1'b1;
    pushStream(32'h0);
    checkOutput({tag, "_valid0"}, 32'(outValid), 32'd0);
    checkOutput({tag, "_fault0"}, 32'(fetchFault), 32'd0);
    checkOutput({tag, "_faultPc0"}, faultPc, 32'd0);
    checkOutput({tag, "_outPc0"}, outPc, 32'd0);
    checkOutput({tag, "_outInstr0"}, outInstr, 32'd0);
    checkOutput({tag, "_addr0"}, imemAddr, 32'd0);
    stepCycle();
    checkOutput({tag, "_valid1"}, 32'(outValid), 32'd0);
    checkOutput({tag, "_addr1"}, imemAddr, 32'd4);
    stepCycle();
    checkOutput({tag, "_valid2"}, 32'(outValid), 32'd1);
    checkOutput({tag, "_addr2"}, imemAddr, 32'd8);
    checkOutput({tag, "_pc2"}, outPc, 32'd0);
  endtask

  initial begin
    int x0;
    logic [31:0] a;
    logic [31:0] p;
    logic        expV4 [8];
    logic [31:0] expPc4 [8];
    logic        expF4 [8];

    rst = 1'b1; rst4 = 1'b1; redirectValid = 1'b0; redirectPc = 32'h0; outReady = 1'b1;
    stepCycle();

    // Streaming from reset, one instruction per cycle.
    resetAndCheck("rst1");
    x0 = xferCount;
    for (int i = 0; i < 9; i++) begin
      a = imemAddr;
      stepCycle();
      checkOutput("addrStep", imemAddr, a + 32'd4);
    end
    checkOutput("streamRate", 32'(xferCount - x0), 32'd9);

    // Decode back-pressure: fetch freezes, nothing lost or duplicated.
    outReady = 1'b0;
    stepCycle();
    a = imemAddr;
    x0 = xferCount;
    repeat (4) stepCycle();
    checkOutput("stallAddr", imemAddr, a);
    checkOutput("stallValid", 32'(outValid), 32'd1);
    checkOutput("stallNoXfer", 32'(xferCount - x0), 32'd0);
    outReady = 1'b1;
    x0 = xferCount;
    repeat (6) stepCycle();
    checkOutput("resumeRate", 32'(xferCount - x0), 32'd6);

    // Redirect with the queue full and decode stalled.
    outReady = 1'b0;
    repeat (3) stepCycle();
    applyStimulus(32'h40);
    pushStream(32'h40);
    outReady = 1'b1;
    checkOutput("redirValidN1", 32'(outValid), 32'd0);
    stepCycle();
    checkOutput("redirValidN2", 32'(outValid), 32'd0);
    stepCycle();
    checkOutput("redirValidN3", 32'(outValid), 32'd1);
    checkOutput("redirPc", outPc, 32'h40);
    checkOutput("redirInstr", outInstr, 32'h110);
    repeat (4) stepCycle();

    // Redirect while streaming: the same-cycle transfer is still consumed.
    applyStimulus(32'h80);
    pushStream(32'h80);
    checkOutput("redir2Valid", 32'(outValid), 32'd0);
    repeat (5) stepCycle();

    // Misaligned redirect faults, a legal redirect recovers.
    applyStimulus(32'h42);
    expQ.delete();
    checkOutput("faultFlag", 32'(fetchFault), 32'd1);
    checkOutput("faultPc", faultPc, 32'h42);
    checkOutput("faultValid", 32'(outValid), 32'd0);
    repeat (3) stepCycle();
    checkOutput("faultSticky", 32'(fetchFault), 32'd1);
    checkOutput("faultQuiet", 32'(outValid), 32'd0);
    applyStimulus(32'h8);
    pushStream(32'h8);
    checkOutput("faultClear", 32'(fetchFault), 32'd0);
    repeat (2) stepCycle();
    checkOutput("recoverPc", outPc, 32'h8);
    checkOutput("recoverValid", 32'(outValid), 32'd1);
    repeat (3) stepCycle();

    // Out-of-range redirect also faults.
    applyStimulus(32'h1000);
    expQ.delete();
    checkOutput("rangeFault", 32'(fetchFault), 32'd1);
    checkOutput("rangeFaultPc", faultPc, 32'h1000);

    // Reset with a full queue and a redirect in the same cycle.
    applyStimulus(32'h20);
    pushStream(32'h20);
    repeat (3) stepCycle();
    outReady = 1'b0;
    repeat (3) stepCycle();
    redirectValid = 1'b1;
    redirectPc = 32'h200;
    resetAndCheck("rst2");
    repeat (4) stepCycle();

    // Sequential overflow on a 4-word memory.
    expV4  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    expPc4 = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h0};
    expF4  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rst4 = 1'b1;
    stepCycle();
    rst4 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      checkOutput($sformatf("ovfValid%0d", c), 32'(outValid4), 32'(expV4[c]));
      checkOutput($sformatf("ovfFault%0d", c), 32'(fetchFault4), 32'(expF4[c]));
      if (expV4[c]) begin
        p = expPc4[c];
        checkOutput($sformatf("ovfPc%0d", c), outPc4, p);
        checkOutput($sformatf("ovfInstr%0d", c), outInstr4, memWord(p));
      end
      stepCycle();
    end
    checkOutput("ovfFaultPc", faultPc4, 32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
